// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters and the RAM.
//   Core port (C): c_req, c_we, c_addr, c_wdata in; c_rdata, c_stall out.
//   DMA port  (D): d_req, d_we, d_addr, d_wdata in; d_gnt, d_rvalid, d_rdata out.
//   Memory port  : m_en, m_we, m_addr, m_wdata out; m_rdata in (1-cycle read latency).
// Modport "slave" is the arbiter's view. Modport "master" is the view of the
// requesters plus the memory that surround it.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic [DW-1:0] c_rdata;
  logic          c_stall;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_rdata, c_stall,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output m_en, m_we, m_addr, m_wdata,
    input  m_rdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_rdata, c_stall,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_en, m_we, m_addr, m_wdata,
    output m_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port synchronous data RAM between the
// single-cycle core's load/store port (C) and a DMA/debug port (D).
// The core has priority; a starvation counter force-grants D after it has
// waited STARVE_LIMIT consecutive cycles. The core is stalled while its access
// is pending (load first cycle) or denied.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-low reset
//   bus   - dmem_arbiter_if.slave carrying the core, DMA and memory signals
module dmem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  localparam int             CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]  LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, C_RD, D_RD} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_starve_cnt;

  logic          w_force;
  logic          w_c_stall;
  logic          w_d_gnt;
  logic          w_d_rvalid;
  logic          w_m_en;
  logic          w_m_we;
  logic [AW-1:0] w_m_addr;
  logic [DW-1:0] w_m_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
    end else begin
      r_state <= w_next;
      // Counts consecutive waiting cycles, including the C_RD/D_RD cycles
      // in which nothing can be granted.
      if (!bus.d_req || w_d_gnt)
        r_starve_cnt <= '0;
      else if (r_starve_cnt != LIMIT)
        r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_c_stall  = 1'b0;
    w_d_gnt    = 1'b0;
    w_d_rvalid = 1'b0;
    w_m_en     = 1'b0;
    w_m_we     = 1'b0;
    w_m_addr   = bus.c_addr;
    w_m_wdata  = bus.c_wdata;
    w_force    = bus.d_req && (r_starve_cnt == LIMIT);

    case (r_state)
      IDLE: begin
        if (w_force || (bus.d_req && !bus.c_req)) begin
          w_d_gnt   = 1'b1;
          w_m_en    = 1'b1;
          w_m_we    = bus.d_we;
          w_m_addr  = bus.d_addr;
          w_m_wdata = bus.d_wdata;
          // A core request losing to D must hold for another cycle.
          w_c_stall = bus.c_req;
          w_next    = bus.d_we ? IDLE : D_RD;
        end else if (bus.c_req) begin
          w_m_en    = 1'b1;
          w_m_we    = bus.c_we;
          // Loads need the RAM's second cycle; stores retire immediately.
          w_c_stall = !bus.c_we;
          w_next    = bus.c_we ? IDLE : C_RD;
        end
      end
      C_RD: begin
        w_next = IDLE;
      end
      D_RD: begin
        w_d_rvalid = 1'b1;
        w_c_stall  = bus.c_req;
        w_next     = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase

    // Outputs are combinational from requests, so gate them during reset too.
    if (!reset) begin
      w_c_stall  = 1'b0;
      w_d_gnt    = 1'b0;
      w_d_rvalid = 1'b0;
      w_m_en     = 1'b0;
      w_m_we     = 1'b0;
      w_next     = IDLE;
    end
  end

  assign bus.c_stall  = w_c_stall;
  assign bus.d_gnt    = w_d_gnt;
  assign bus.d_rvalid = w_d_rvalid;
  assign bus.m_en     = w_m_en;
  assign bus.m_we     = w_m_we;
  assign bus.m_addr   = w_m_addr;
  assign bus.m_wdata  = w_m_wdata;
  assign bus.c_rdata  = bus.m_rdata;
  assign bus.d_rdata  = bus.m_rdata;

endmodule
